// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART framing constants and receiver state encoding shared by uart_tx/uart_rx
package uart_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - reset-to-idle (1) input synchroniser, STAGES flops deep, 0 = pass-through
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q = d;
    end else begin : g_flops
      logic [STAGES-1:0] s;

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          s <= '1;
        end else begin
          s[0] <= d;
          for (int i = 1; i < STAGES; i++) begin
            s[i] <= s[i-1];
          end
        end
      end

      assign q = s[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: synchronised rx, mid-bit sampling, one-byte holding register,
// framing-error and overrun pulses
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT + 1);
  localparam int BW   = $clog2(UART_DATA_BITS);

  localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_RELOAD = TW'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [BW-1:0] MSB_IDX     = BW'(UART_DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_START = START;
  localparam logic [2:0] S_DATA  = DATA;
  localparam logic [2:0] S_STOP  = STOP;
  localparam logic [2:0] S_BREAK = BREAK;

  logic                      rx_s;
  logic [2:0]                state;
  logic [TW-1:0]             timer;
  logic [BW-1:0]             bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      sample;
  logic                      good_stop;
  logic                      bad_stop;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .d       (rx),
    .q       (rx_s)
  );

  // timer counts down to the next sample point; zero means "sample this cycle"
  assign sample    = (timer == '0);
  assign good_stop = (state == S_STOP) && sample && (rx_s == STOP_BIT);
  assign bad_stop  = (state == S_STOP) && sample && (rx_s != STOP_BIT);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_s == START_BIT) begin
            // at one clock per bit the start check falls on the detection cycle itself
            if (HALF == 0) begin
              state   <= S_DATA;
              timer   <= BIT_RELOAD;
              bit_idx <= MSB_IDX;
            end else begin
              state <= S_START;
              timer <= HALF_RELOAD;
            end
          end
        end
        S_START: begin
          if (sample) begin
            if (rx_s == START_BIT) begin
              state   <= S_DATA;
              timer   <= BIT_RELOAD;
              bit_idx <= MSB_IDX;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_DATA: begin
          if (sample) begin
            shreg[bit_idx] <= rx_s;
            timer          <= BIT_RELOAD;
            if (bit_idx == '0) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx - BW'(1);
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_STOP: begin
          if (sample) begin
            state <= (rx_s == STOP_BIT) ? S_IDLE : S_BREAK;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_BREAK: begin
          if (rx_s == STOP_BIT) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // a delivery coinciding with a consume refills the register without an overrun
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= good_stop && valid && !ready;
      if (good_stop && (!valid || ready)) begin
        data  <= shreg;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
